// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared phase encoding and lamp words for the traffic phase
//               controller and its approach arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Junction phase; the encoding is fixed so a stray value falls to ALL_RED
  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_AMBER   = 2'd2
  } state_t;

  // Lamp word layout per approach: {red, amber, left, front, right}
  localparam logic [4:0] LAMP_RED   = 5'b10000;
  localparam logic [4:0] LAMP_AMBER = 5'b01000;
  localparam logic [4:0] LAMP_GREEN = 5'b00111;

  // Lamp word for one approach given the phase and whether it owns the phase
  function automatic logic [4:0] lamp_for(input state_t st, input logic is_active);
    logic [4:0] w;
    w = LAMP_RED;
    if (is_active && st == ST_GREEN) w = LAMP_GREEN;
    if (is_active && st == ST_AMBER) w = LAMP_AMBER;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dir_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dir_arbiter
// Description : Combinational three-tier approach selector: lowest emergency
//               request, else lowest priority request, else round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module dir_arbiter #(
  parameter  int NUM_DIR = 4,
  localparam int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] i_e_req,
  input  logic [NUM_DIR-1:0] i_p_req,
  input  logic [DIR_W-1:0]   i_cur_dir,
  input  logic               i_advance,
  output logic [DIR_W-1:0]   o_sel_dir
);

  logic             w_e_hit;
  logic             w_p_hit;
  logic [DIR_W-1:0] w_e_idx;
  logic [DIR_W-1:0] w_p_idx;
  logic [DIR_W-1:0] w_rr_idx;

  // Scan downwards so the last hit written is the lowest set index
  always_comb begin
    w_e_hit = 1'b0;
    w_p_hit = 1'b0;
    w_e_idx = '0;
    w_p_idx = '0;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (i_e_req[i]) begin
        w_e_hit = 1'b1;
        w_e_idx = DIR_W'(i);
      end
      if (i_p_req[i]) begin
        w_p_hit = 1'b1;
        w_p_idx = DIR_W'(i);
      end
    end
  end

  // Round-robin successor; the first selection after reset keeps approach 0
  always_comb begin
    w_rr_idx = i_cur_dir;
    if (i_advance) begin
      if (i_cur_dir == DIR_W'(NUM_DIR - 1)) w_rr_idx = '0;
      else                                  w_rr_idx = i_cur_dir + 1'b1;
    end
  end

  // Tier priority: emergency, then priority load, then round-robin
  always_comb begin
    o_sel_dir = w_rr_idx;
    if (w_p_hit) o_sel_dir = w_p_idx;
    if (w_e_hit) o_sel_dir = w_e_idx;
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl
// Description : N-approach traffic phase controller. Cycles ALL_RED -> GREEN
//               -> AMBER with emergency truncation/extension and
//               request-steered approach selection. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR   = 4,
  parameter  int GREEN_CYC = 16,
  parameter  int AMBER_CYC = 4,
  parameter  int CNT_W     = 6,
  localparam int DIR_W     = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIR-1:0]   p_req,
  input  logic [NUM_DIR-1:0]   e_req,
  output logic [5*NUM_DIR-1:0] light,
  output logic [DIR_W-1:0]     active_dir,
  output logic [CNT_W-1:0]     countdown,
  output logic                 phase_start,
  output logic                 emergency_active
);

  // Parameter legality is enforced at elaboration
  generate
    if (NUM_DIR < 2) begin : g_chk_num_dir
      $error("traffic_phase_ctrl: NUM_DIR must be at least 2");
    end
    if (GREEN_CYC < 1 || GREEN_CYC > (1 << CNT_W)) begin : g_chk_green
      $error("traffic_phase_ctrl: GREEN_CYC out of range for CNT_W");
    end
    if (AMBER_CYC < 1 || AMBER_CYC > (1 << CNT_W)) begin : g_chk_amber
      $error("traffic_phase_ctrl: AMBER_CYC out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_green_load = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] c_amber_load = CNT_W'(AMBER_CYC - 1);

  state_t             r_state;
  logic               r_init_done;   // first ALL_RED after reset is a hold cycle
  logic               r_first_sel;   // no round-robin advance until first green
  logic [DIR_W-1:0]   w_sel_dir;
  logic [NUM_DIR-1:0] w_active_mask;
  logic               w_truncate;

  // Full lamp vector for a given phase and owning approach
  function automatic logic [5*NUM_DIR-1:0] f_lamps(input state_t st,
                                                   input logic [DIR_W-1:0] dir);
    logic [5*NUM_DIR-1:0] v;
    for (int d = 0; d < NUM_DIR; d++) begin
      v[5*d +: 5] = lamp_for(st, DIR_W'(d) == dir);
    end
    return v;
  endfunction

  dir_arbiter #(
    .NUM_DIR (NUM_DIR)
  ) u_dir_arbiter (
    .i_e_req   (e_req),
    .i_p_req   (p_req),
    .i_cur_dir (active_dir),
    .i_advance (~r_first_sel),
    .o_sel_dir (w_sel_dir)
  );

  // Any emergency on an approach other than the green owner ends green early
  assign w_active_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << active_dir;
  assign w_truncate    = |(e_req & ~w_active_mask);

  // Phase FSM with every output registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_ALL_RED;
      r_init_done      <= 1'b0;
      r_first_sel      <= 1'b1;
      light            <= {NUM_DIR{LAMP_RED}};
      active_dir       <= '0;
      countdown        <= '0;
      phase_start      <= 1'b0;
      emergency_active <= 1'b0;
    end else begin
      phase_start      <= 1'b0;
      emergency_active <= 1'b0;
      case (r_state)
        ST_ALL_RED: begin
          countdown <= '0;
          light     <= {NUM_DIR{LAMP_RED}};
          if (!r_init_done) begin
            r_init_done <= 1'b1;
          end else begin
            r_state     <= ST_GREEN;
            r_first_sel <= 1'b0;
            active_dir  <= w_sel_dir;
            countdown   <= c_green_load;
            phase_start <= 1'b1;
            light       <= f_lamps(ST_GREEN, w_sel_dir);
          end
        end
        ST_GREEN: begin
          if (w_truncate || (!e_req[active_dir] && countdown == '0)) begin
            r_state   <= ST_AMBER;
            countdown <= c_amber_load;
            light     <= f_lamps(ST_AMBER, active_dir);
          end else if (e_req[active_dir]) begin
            emergency_active <= 1'b1;
          end else begin
            countdown <= countdown - 1'b1;
          end
        end
        ST_AMBER: begin
          if (countdown == '0) begin
            r_state <= ST_ALL_RED;
            light   <= {NUM_DIR{LAMP_RED}};
          end else begin
            countdown <= countdown - 1'b1;
          end
        end
        default: begin
          r_state   <= ST_ALL_RED;
          countdown <= '0;
          light     <= {NUM_DIR{LAMP_RED}};
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_ctrl
// Description : Directed self-checking bench for traffic_phase_ctrl at
//               default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

  localparam int c_ph_red   = 0;
  localparam int c_ph_green = 1;
  localparam int c_ph_amber = 2;

  logic        clk;
  logic        reset;
  logic [3:0]  p_req;
  logic [3:0]  e_req;
  logic [19:0] light;
  logic [1:0]  active_dir;
  logic [5:0]  countdown;
  logic        phase_start;
  logic        emergency_active;

  int checks;
  int errors;

  traffic_phase_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .p_req            (p_req),
    .e_req            (e_req),
    .light            (light),
    .active_dir       (active_dir),
    .countdown        (countdown),
    .phase_start      (phase_start),
    .emergency_active (emergency_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamp vector: owner shows green/amber, everyone else red
  function automatic logic [19:0] lamps(input int ph, input int dir);
    logic [19:0] v;
    for (int d = 0; d < 4; d++) begin
      v[5*d +: 5] = 5'b10000;
      if (d == dir && ph == c_ph_green) v[5*d +: 5] = 5'b00111;
      if (d == dir && ph == c_ph_amber) v[5*d +: 5] = 5'b01000;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle just after the last one
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    p_req  = '0;
    e_req  = '0;
    step(2);
    chk("rst_light", 32'(light), 32'(lamps(c_ph_red, 0)));
    chk("rst_cd", 32'(countdown), 32'd0);
    chk("rst_dir", 32'(active_dir), 32'd0);
    chk("rst_ps", 32'(phase_start), 32'd0);
    chk("rst_emg", 32'(emergency_active), 32'd0);

    // Unperturbed first phase
    reset = 1'b0;
    step(1);                                           // edge 1
    chk("e1_light", 32'(light), 32'(lamps(c_ph_red, 0)));
    chk("e1_ps", 32'(phase_start), 32'd0);
    step(1);                                           // edge 2
    chk("e2_ps", 32'(phase_start), 32'd1);
    chk("e2_cd", 32'(countdown), 32'd15);
    chk("e2_light", 32'(light), 32'(lamps(c_ph_green, 0)));
    step(1);                                           // edge 3
    chk("e3_ps", 32'(phase_start), 32'd0);
    chk("e3_cd", 32'(countdown), 32'd14);
    step(14);                                          // edge 17
    chk("e17_cd", 32'(countdown), 32'd0);
    chk("e17_light", 32'(light), 32'(lamps(c_ph_green, 0)));
    step(1);                                           // edge 18
    chk("e18_light", 32'(light), 32'(lamps(c_ph_amber, 0)));
    chk("e18_cd", 32'(countdown), 32'd3);
    step(3);                                           // edge 21
    chk("e21_cd", 32'(countdown), 32'd0);
    chk("e21_light", 32'(light), 32'(lamps(c_ph_amber, 0)));
    step(1);                                           // edge 22
    chk("e22_light", 32'(light), 32'(lamps(c_ph_red, 0)));
    step(1);                                           // edge 23
    chk("e23_dir", 32'(active_dir), 32'd1);
    chk("e23_ps", 32'(phase_start), 32'd1);
    chk("e23_light", 32'(light), 32'(lamps(c_ph_green, 1)));

    // Round-robin through dir2, dir3 and wrap to dir0
    step(21);                                          // edge 44
    chk("rr_dir2", 32'(active_dir), 32'd2);
    step(21);                                          // edge 65
    chk("rr_dir3", 32'(active_dir), 32'd3);
    chk("rr_dir3_light", 32'(light), 32'(lamps(c_ph_green, 3)));
    step(21);                                          // edge 86
    chk("rr_wrap_dir", 32'(active_dir), 32'd0);
    chk("rr_wrap_ps", 32'(phase_start), 32'd1);

    // Priority request steers selection, never truncates
    p_req = 4'b0100;
    step(16);                                          // edge 102
    chk("pr_amber_light", 32'(light), 32'(lamps(c_ph_amber, 0)));
    chk("pr_amber_cd", 32'(countdown), 32'd3);
    step(4);                                           // edge 106
    chk("pr_allred", 32'(light), 32'(lamps(c_ph_red, 0)));
    step(1);                                           // edge 107
    chk("pr_dir", 32'(active_dir), 32'd2);
    chk("pr_light", 32'(light), 32'(lamps(c_ph_green, 2)));
    p_req = 4'b0000;

    // Emergency truncation on dir0, then extension on dir3
    step(42);                                          // edge 149
    chk("em_dir0", 32'(active_dir), 32'd0);
    step(5);                                           // edge 154
    chk("em_cd10", 32'(countdown), 32'd10);
    e_req = 4'b1000;
    step(1);                                           // edge 155
    chk("em_trunc_light", 32'(light), 32'(lamps(c_ph_amber, 0)));
    chk("em_trunc_cd", 32'(countdown), 32'd3);
    chk("em_trunc_emg", 32'(emergency_active), 32'd0);
    step(3);                                           // edge 158
    chk("em_amber_end", 32'(light), 32'(lamps(c_ph_amber, 0)));
    step(1);                                           // edge 159
    chk("em_allred", 32'(light), 32'(lamps(c_ph_red, 0)));
    step(1);                                           // edge 160
    chk("em_dir3", 32'(active_dir), 32'd3);
    chk("em_g1_emg", 32'(emergency_active), 32'd0);
    chk("em_g1_cd", 32'(countdown), 32'd15);
    step(1);                                           // edge 161
    chk("em_g2_emg", 32'(emergency_active), 32'd1);
    chk("em_g2_cd", 32'(countdown), 32'd15);
    step(3);                                           // edge 164
    chk("em_hold_cd", 32'(countdown), 32'd15);
    chk("em_hold_light", 32'(light), 32'(lamps(c_ph_green, 3)));
    e_req = 4'b0000;
    step(1);                                           // edge 165
    chk("em_resume_cd", 32'(countdown), 32'd14);
    chk("em_resume_emg", 32'(emergency_active), 32'd0);
    step(14);                                          // edge 179
    chk("em_resume_zero", 32'(countdown), 32'd0);

    // Emergency outranks priority in selection
    step(1);                                           // edge 180 (amber)
    e_req = 4'b0110;
    p_req = 4'b0001;
    step(5);                                           // edge 185
    chk("sim_dir", 32'(active_dir), 32'd1);
    chk("sim_ps", 32'(phase_start), 32'd1);
    e_req = 4'b0000;
    p_req = 4'b0000;

    // Reset in the middle of amber
    step(16);                                          // edge 201
    chk("ra_amber", 32'(light), 32'(lamps(c_ph_amber, 1)));
    step(1);                                           // edge 202
    reset = 1'b1;
    step(1);
    chk("ra_light", 32'(light), 32'(lamps(c_ph_red, 0)));
    chk("ra_cd", 32'(countdown), 32'd0);
    chk("ra_dir", 32'(active_dir), 32'd0);
    reset = 1'b0;
    step(1);
    chk("ra_e1_light", 32'(light), 32'(lamps(c_ph_red, 0)));
    step(1);
    chk("ra_e2_dir", 32'(active_dir), 32'd0);
    chk("ra_e2_ps", 32'(phase_start), 32'd1);
    chk("ra_e2_light", 32'(light), 32'(lamps(c_ph_green, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
